regfile_scoreboard: RTL

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 60 ++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register pending scoreboard with issue stall, two-port writeback arbitration and error flag
module regfile_scoreboard #(
  parameter int N  = 64,
  parameter int ZR = 31
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         issue_valid_D,
  input  logic [4:0]   ra1_D,
  input  logic [4:0]   ra2_D,
  input  logic         use_ra2_D,
  input  logic         issue_we_D,
  input  logic [4:0]   issue_wa_D,
  output logic         stall_D,
  input  logic         wbA_valid,
  input  logic [4:0]   wbA_wa,
  input  logic [N-1:0] wbA_data,
  input  logic         wbB_valid,
  input  logic [4:0]   wbB_wa,
  input  logic [N-1:0] wbB_data,
  output logic         wbB_ready,
  output logic         we3,
  output logic [4:0]   wa3,
  output logic [N-1:0] wd3,
  output logic [5:0]   pend_count,
  output logic         wb_err
);
  localparam logic [4:0] ZI = 5'(ZR);
  logic [31:0] pending, set_m, clr_m, pend_nxt;
  logic [5:0]  cnt_nxt;
  logic        p1, p2, pw, issue_ok, wb_live;
  assign p1        = pending[ra1_D] & (ra1_D != ZI);
  assign p2        = pending[ra2_D] & (ra2_D != ZI);
  assign pw        = pending[issue_wa_D] & (issue_wa_D != ZI);
  assign stall_D   = issue_valid_D & (p1 | (use_ra2_D & p2) | (issue_we_D & pw));
  assign issue_ok  = issue_valid_D & ~stall_D;
  assign wbB_ready = ~wbA_valid;
  assign we3       = wbA_valid | wbB_valid;
  assign wa3       = wbA_valid ? wbA_wa : wbB_wa;
  assign wd3       = wbA_valid ? wbA_data : wbB_data;
  assign wb_live   = we3 & (wa3 != ZI);
  assign set_m     = (issue_ok & issue_we_D & (issue_wa_D != ZI)) ? (32'd1 << issue_wa_D) : 32'd0;
  assign clr_m     = wb_live ? (32'd1 << wa3) : 32'd0;
  assign pend_nxt  = (pending & ~clr_m) | set_m;
  always_comb begin
    cnt_nxt = 6'd0;
    for (int i = 0; i < 32; i++) cnt_nxt = cnt_nxt + 6'(pend_nxt[i]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= 32'd0;
      pend_count <= 6'd0;
      wb_err     <= 1'b0;
    end else begin
      pending    <= pend_nxt;
      pend_count <= cnt_nxt;
      wb_err     <= wb_err | (wb_live & ~pending[wa3]);
    end
  end
endmodule
